button_event: RTL
=================

Name: button_event

Overview:
- Sits directly downstream of the button debouncer and consumes its clean, same-clock level output.
- Turns that level into single-cycle UI events for the control logic: press, release, long-press and auto-repeat.
- The control logic (pause/reset/adjust) then acts on pulses rather than on levels.
- No synchronizer: the input already belongs to the `clk` domain.

Parameters:
- HOLD_CYCLES, default 50_000_000: cycles the button must stay high after the press before the long-press event fires. Legal range ≥ 2.
- REPEAT_CYCLES, default 12_500_000: period of auto-repeat pulses after the long-press. Legal range ≥ 1.
- REPEAT_EN, default 1: 1 enables auto-repeat; 0 suppresses `repeat_pulse`, and the block stays in HELD until release.
- CNT_W, default 26: hold/repeat counter width. Must satisfy 2^CNT_W ≥ max(HOLD_CYCLES, REPEAT_CYCLES).

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- btn_in  input  1  debounced button level from the debouncer
- press_pulse  output  1  one-cycle pulse on accepted press
- release_pulse  output  1  one-cycle pulse on release of an accepted press
- long_pulse  output  1  one-cycle pulse when hold reaches HOLD_CYCLES
- repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES while held past long-press
- held  output  1  level; high while state ≠ IDLE

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is asynchronous and active-high: `rst` assertion immediately forces the block to its reset state without waiting for a clock edge.
- Reset values:
  - state = IDLE, cnt = 0, btn_prev = 1.
  - All pulse outputs = 0, held = 0.
  - Because btn_prev resets to 1, a button held through reset produces no press. It must be seen low for at least one cycle before a press is accepted, and its eventual release produces no release_pulse.
- Output registration:
  - All outputs are registered.
  - Every pulse is high for exactly one cycle and defaults to 0 on every edge where it is not explicitly set.
- State machine: IDLE, PRESSED, HELD. btn_prev ← btn_in on every edge.
- IDLE:
  - If btn_in=1 and btn_prev=0 at edge T: press_pulse←1, state←PRESSED, cnt←0.
  - Otherwise stay in IDLE.
- PRESSED:
  - If btn_in=0: release_pulse←1, state←IDLE, cnt←0.
  - Else if cnt = HOLD_CYCLES−1: long_pulse←1, state←HELD, cnt←0.
  - Else: cnt←cnt+1.
- HELD:
  - If btn_in=0: release_pulse←1, state←IDLE, cnt←0.
  - Else if REPEAT_EN and cnt = REPEAT_CYCLES−1: repeat_pulse←1, cnt←0.
  - Else if REPEAT_EN: cnt←cnt+1.
  - If REPEAT_EN=0, cnt holds at 0.
- Event timing, with the press accepted at edge T:
  - press_pulse at edge T.
  - long_pulse at edge T+HOLD_CYCLES.
  - repeat_pulse at edges T+HOLD_CYCLES+k·REPEAT_CYCLES, k ≥ 1.
  - held rises at edge T and falls at the release edge.
- Simultaneous events:
  - Release wins over a terminal count: no long_pulse or repeat_pulse is generated on the release edge.
  - At most one pulse output is high in any cycle.
- Back-to-back presses:
  - A release at edge R followed by btn_in=1 at R+1 is a new press: press_pulse at R+1, since btn_prev=0 at that point.
  - Minimum press-to-press spacing is therefore 2 cycles.
- Reset mid-operation:
  - Any state returns to IDLE and no pulse is emitted.
  - After reset, a still-high button requires a low cycle before the next press is accepted.
- Counter:
  - Unsigned, CNT_W bits.
  - Never exceeds max(HOLD_CYCLES, REPEAT_CYCLES)−1.
  - No wrap-around is reachable under legal parameters.

Test Plan:
1. HOLD=4, REPEAT=3, btn_in low 2 cycles then high held 15 cycles (press edge T) → press_pulse at T; long_pulse at T+4; repeat_pulse at T+7, T+10, T+13; held high T..release.
2. Same params, btn_in high 3 cycles then low at edge T+3 → press_pulse at T, release_pulse at T+3, no long_pulse, held low from T+3.
3. HOLD=4, btn_in falls exactly at edge T+4 → release_pulse at T+4, long_pulse never asserted.
4. REPEAT_EN=0, HOLD=4, hold for 20 cycles → exactly one long_pulse at T+4, zero repeat_pulse; release_pulse one cycle after release.
5. btn_in high before and through deassertion of rst, then low, then high again → no press or release pulse for the first hold; press_pulse on the second rising level.
6. rst asserted asynchronously mid-HELD → outputs zero immediately; no release_pulse when btn_in later falls; next clean press gives press_pulse normally.

Source files
------------

// File: rtl/button_event.sv
// Converts a debounced, same-clock button level into single-cycle UI events:
// press, release, long-press after HOLD_CYCLES and optional auto-repeat.
module button_event #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 12_500_000,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int CNT_W         = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             btn_prev;
  logic             press_next, release_next, long_next, repeat_next, held_next;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    press_next   = 1'b0;
    release_next = 1'b0;
    long_next    = 1'b0;
    repeat_next  = 1'b0;

    case (state)
      IDLE: begin
        // A rising level is only accepted after the button was seen low.
        if (btn_in && !btn_prev) begin
          press_next = 1'b1;
          state_next = PRESSED;
          cnt_next   = '0;
        end
      end

      PRESSED: begin
        if (!btn_in) begin
          release_next = 1'b1;
          state_next   = IDLE;
          cnt_next     = '0;
        end else if (cnt == HOLD_LAST) begin
          long_next  = 1'b1;
          state_next = HELD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      HELD: begin
        // Release is tested first so it wins over a terminal count.
        if (!btn_in) begin
          release_next = 1'b1;
          state_next   = IDLE;
          cnt_next     = '0;
        end else if (REPEAT_EN) begin
          if (cnt == REPEAT_LAST) begin
            repeat_next = 1'b1;
            cnt_next    = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end else begin
          cnt_next = '0;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    held_next = (state_next != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_prev      <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      btn_prev      <= btn_in;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      long_pulse    <= long_next;
      repeat_pulse  <= repeat_next;
      held          <= held_next;
    end
  end

endmodule
